xcr_xcp_src_cond: RTL
=====================

Name: xcr_xcp_src_cond

Overview:
- Per-source conditioning front end for exception/interrupt lines; sits directly upstream of the interrupt/exception controller in the XCR block.
- Synchronises raw asynchronous sources to clk and applies per-bit polarity.
- Edge-mode bits are latched as pending until software acknowledges them; level-mode bits pass through as a registered level.
- Drives the controller's XCP_ARR/INT_ARR inputs with glitch-free, clk-domain levels, replacing asynchronous posedge latching.

Parameters:
- N, 8, number of source bits
- SYNC_STAGES, 2, synchroniser depth (>=2)
- DB_CYCLES, 4, debounce stability count in clk cycles (>=1); used only with XCR_SRC_DEBOUNCE_EN

Ports:
- clk  input  1  system clock
- xcp_clr  input  1  reset, asynchronous, active-high
- src_in  input  N  raw asynchronous source lines
- pol  input  N  per-bit polarity: 1 = active-high, 0 = active-low
- mode  input  N  per-bit mode: 1 = edge-capture (pending latch), 0 = level pass-through
- ack  input  N  per-bit one-cycle clear of pending (edge mode only)
- ovr_clr  input  1  one-cycle clear of all overrun flags
- xcp_arr  output  N  conditioned request vector to interrupt/exception controller
- edge_pulse  output  N  one-cycle pulse per detected active edge
- overrun  output  N  sticky: active edge arrived while pending already set
- ready  output  1  high once warm-up is complete

Behaviour:
- Reset (xcp_clr = 1, asynchronous): all synchroniser flops, filter state, prev-level regs, pending, xcp_arr, edge_pulse and overrun go to 0; ready = 0; warm-up counter = 0.
- Synchroniser: src_in passes through a SYNC_STAGES flop chain per bit, giving s[i].
- Filter: f[i] = s[i] without the optional feature (see Optional Feature).
- Conditioned level: c[i] = f[i] XNOR pol[i].
- Prev register: p[i] <= c[i] every cycle, including during warm-up.
- Edge detect: e[i] = c[i] & ~p[i] & ready & mode[i].
- Warm-up:
  - Counter runs SYNC_STAGES+1 cycles after reset release, then sets ready = 1 (sticky until reset).
  - While ready = 0: xcp_arr, edge_pulse and pending are forced to 0, so an active-low source held idle cannot fake an edge at reset release.
- Edge mode (mode[i] = 1):
  - pending[i] next = e[i] | (pending[i] & ~ack[i]).
  - Set wins over ack in the same cycle.
  - xcp_arr[i] = pending[i] (registered).
  - edge_pulse[i] <= e[i].
- Overrun:
  - overrun[i] set when e[i] & pending[i] & ~ack[i].
  - Cleared by ovr_clr, but a set in the same cycle wins.
- Level mode (mode[i] = 0):
  - xcp_arr[i] <= c[i] & ready.
  - pending[i] forced to 0; ack[i] ignored; edge_pulse[i] = 0; overrun[i] holds its value.
- Latency: src_in change meeting setup before edge k gives an xcp_arr/edge_pulse update at edge k+SYNC_STAGES+1 (k+3 at defaults), in both modes.
- Runtime mode change:
  - 1->0: pending discarded next cycle.
  - 0->1: p tracks continuously, so no edge is generated unless c actually rises.
- Runtime pol change: inverts c and can produce one genuine edge. This is legal; software acks after changing pol.
- Pulses narrower than one clk period may be lost. Only edges visible after synchronisation count.
- Mid-operation reset: all state, including pending and overrun, is lost immediately; warm-up restarts.

Optional Feature:
- Macro: XCR_SRC_DEBOUNCE_EN
- Enabled:
  - Per-bit counter, width $clog2(DB_CYCLES+1).
  - While s[i] != f[i], the counter increments. When it reaches DB_CYCLES, f[i] <= s[i] and the counter clears.
  - Any cycle with s[i] == f[i] clears the counter.
  - Added latency is exactly DB_CYCLES cycles. Glitches shorter than DB_CYCLES cycles are suppressed.
- Disabled: no counters; f = s; latency as stated above.

Test Plan:
- Reset then idle; pol=8'h00, mode=8'hFF, src_in=8'hFF held -> xcp_arr, edge_pulse, overrun stay 8'h00 forever; ready rises 3 clks after reset release.
- pol=8'hFF, mode=8'h01; src_in[0] 0->1 before edge k -> edge_pulse=8'h01 for one cycle at k+3; xcp_arr[0]=1 held; ack=8'h01 pulse -> xcp_arr[0]=0 next cycle.
- Second rising edge on bit 0 while pending, no ack -> overrun=8'h01; then ack and edge in the same cycle -> pending stays 1, overrun unchanged; ovr_clr -> overrun=8'h00.
- mode=8'h00, pol=8'hFF; src_in=8'hA5 -> xcp_arr=8'hA5 after 3 clks; ack=8'hFF has no effect; src_in=8'h00 -> xcp_arr=8'h00 after 3 clks.
- Assert xcp_clr mid-pending (xcp_arr=8'h81) -> xcp_arr=8'h00 immediately (asynchronous); after release, no edges reported until ready=1.
- XCR_SRC_DEBOUNCE_EN, DB_CYCLES=4: 3-cycle high glitch on src_in[2] -> no response; 5-cycle high -> edge_pulse[2] at 3+4 cycles after rise.

Source files
------------

// File: rtl/xcr_xcp_src_cond.sv
// rtl/xcr_xcp_src_cond.sv - per-source sync, polarity, edge-capture conditioning for the XCR controller
// Optional debounce filter is built when XCR_SRC_DEBOUNCE_EN is defined.
module xcr_xcp_src_cond #(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic         clk,
    input  logic         xcp_clr,
    input  logic [N-1:0] src_in,
    input  logic [N-1:0] pol,
    input  logic [N-1:0] mode,
    input  logic [N-1:0] ack,
    input  logic         ovr_clr,
    output logic [N-1:0] xcp_arr,
    output logic [N-1:0] edge_pulse,
    output logic [N-1:0] overrun,
    output logic         ready
);

    localparam int WUW = $clog2(SYNC_STAGES + 1);
    localparam logic [WUW-1:0] WU_LAST = WUW'(SYNC_STAGES);

    if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_bad_param
        $error("xcr_xcp_src_cond: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
    end

    logic [N-1:0]   sync_q [SYNC_STAGES];
    logic [N-1:0]   sync_s;
    logic [N-1:0]   filt_q;
    logic [N-1:0]   cond;
    logic [N-1:0]   prev_q;
    logic [N-1:0]   edge_det;
    logic [N-1:0]   pend_q;
    logic [N-1:0]   pend_d;
    logic [N-1:0]   ovr_q;
    logic [N-1:0]   ovr_d;
    logic [N-1:0]   arr_q;
    logic [N-1:0]   arr_d;
    logic [N-1:0]   pulse_q;
    logic [N-1:0]   pulse_d;
    logic [WUW-1:0] wu_q;
    logic           ready_q;

    always_ff @(posedge clk or posedge xcp_clr) begin
        if (xcp_clr) begin
            for (int j = 0; j < SYNC_STAGES; j++) begin
                sync_q[j] <= '0;
            end
        end else begin
            sync_q[0] <= src_in;
            for (int j = 1; j < SYNC_STAGES; j++) begin
                sync_q[j] <= sync_q[j-1];
            end
        end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    // The filter stage is a register in both builds; it is the "+1" of the
    // SYNC_STAGES+1 input-to-output latency.
`ifdef XCR_SRC_DEBOUNCE_EN
    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES);

    logic [DBW-1:0] db_cnt_q [N];

    always_ff @(posedge clk or posedge xcp_clr) begin
        if (xcp_clr) begin
            filt_q <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (sync_s[i] == filt_q[i]) begin
                    db_cnt_q[i] <= '0;
                end else if (db_cnt_q[i] == DB_LAST) begin
                    filt_q[i]   <= sync_s[i];
                    db_cnt_q[i] <= '0;
                end else begin
                    db_cnt_q[i] <= db_cnt_q[i] + DBW'(1);
                end
            end
        end
    end
`else
    always_ff @(posedge clk or posedge xcp_clr) begin
        if (xcp_clr) begin
            filt_q <= '0;
        end else begin
            filt_q <= sync_s;
        end
    end
`endif

    assign cond     = ~(filt_q ^ pol);
    assign edge_det = cond & ~prev_q & mode & {N{ready_q}};

    // Set beats ack for pending; set beats ovr_clr for overrun.
    always_comb begin
        pend_d  = (edge_det | (pend_q & ~ack)) & mode & {N{ready_q}};
        ovr_d   = (ovr_q & ~{N{ovr_clr}}) | (edge_det & pend_q & ~ack);
        arr_d   = (mode & pend_d) | (~mode & cond & {N{ready_q}});
        pulse_d = edge_det;
    end

    always_ff @(posedge clk or posedge xcp_clr) begin
        if (xcp_clr) begin
            prev_q  <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            arr_q   <= '0;
            pulse_q <= '0;
        end else begin
            prev_q  <= cond;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            arr_q   <= arr_d;
            pulse_q <= pulse_d;
        end
    end

    // Warm-up hides the reset-value transient of the sync/filter chain.
    always_ff @(posedge clk or posedge xcp_clr) begin
        if (xcp_clr) begin
            wu_q    <= '0;
            ready_q <= 1'b0;
        end else if (!ready_q) begin
            if (wu_q == WU_LAST) begin
                ready_q <= 1'b1;
            end else begin
                wu_q <= wu_q + WUW'(1);
            end
        end
    end

    assign xcp_arr    = arr_q;
    assign edge_pulse = pulse_q;
    assign overrun    = ovr_q;
    assign ready      = ready_q;

endmodule
